// File: rtl/sdram_uut.sv
// Wishbone classic slave fronting an on-chip SDRAM model: a controller FSM
// (init, activate, read/write, CAS wait, precharge, auto-refresh) plus the storage array.
module sdram_uut #(
   parameter int DEPTH_WORDS  = 4096,
   parameter int INIT_CYCLES  = 8,
   parameter int T_RCD        = 2,
   parameter int CAS_LAT      = 2,
   parameter int T_RP         = 2,
   parameter int REF_INTERVAL = 750,
   parameter int T_RFC        = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [2:0]  dbg_state
);

   localparam int AW  = $clog2(DEPTH_WORDS);
   localparam int CW  = $clog2(INIT_CYCLES + T_RCD + CAS_LAT + T_RP + T_RFC + 1);
   localparam int RCW = $clog2(REF_INTERVAL);

   localparam logic [CW-1:0]  INIT_LAST = CW'(INIT_CYCLES - 1);
   localparam logic [CW-1:0]  RCD_LAST  = CW'(T_RCD - 1);
   localparam logic [CW-1:0]  CL_LAST   = CW'(CAS_LAT - 1);
   localparam logic [CW-1:0]  RP_LAST   = CW'(T_RP - 1);
   localparam logic [CW-1:0]  RFC_LAST  = CW'(T_RFC - 1);
   localparam logic [RCW-1:0] REF_LAST  = RCW'(REF_INTERVAL - 1);

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_IDLE      = 3'd1,
      ST_ACTIVE    = 3'd2,
      ST_RW        = 3'd3,
      ST_CL_WAIT   = 3'd4,
      ST_ACK       = 3'd5,
      ST_PRECHARGE = 3'd6,
      ST_REFRESH   = 3'd7
   } state_t;

   state_t          state;
   logic [CW-1:0]   wait_cnt;
   logic [RCW-1:0]  ref_cnt;
   logic            refresh_due;
   logic            ack_q;
   logic            req_we;
   logic [AW-1:0]   req_idx;
   logic [31:0]     req_dat;
   logic [31:0]     rd_pipe;
   logic [31:0]     mem [DEPTH_WORDS];

   // Only the word index matters; byte lanes and high address bits are don't-care.
   logic unused_bits;
   assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

   // Handshake: a request is stb&cyc as seen in IDLE; once taken the inputs are ignored
   // until the access retires, and ack pulses for the single ACK cycle, gated by live stb&cyc.
   assign wbs_ack_o = ack_q & wbs_stb_i & wbs_cyc_i;
   assign dbg_state = state;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state       <= ST_INIT;
         wait_cnt    <= '0;
         ref_cnt     <= '0;
         refresh_due <= 1'b0;
         ack_q       <= 1'b0;
         wbs_dat_o   <= '0;
         req_we      <= 1'b0;
         req_idx     <= '0;
         req_dat     <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            ST_INIT: begin
               if (wait_cnt == INIT_LAST) begin
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               wait_cnt <= '0;
               if (refresh_due) begin
                  refresh_due <= 1'b0;
                  state       <= ST_REFRESH;
               end else if (wbs_stb_i && wbs_cyc_i) begin
                  req_we  <= wbs_we_i;
                  req_idx <= wbs_adr_i[AW+1:2];
                  req_dat <= wbs_dat_i;
                  state   <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (wait_cnt == RCD_LAST) begin
                  wait_cnt <= '0;
                  state    <= ST_RW;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RW: begin
               wait_cnt <= '0;
               if (req_we) begin
                  ack_q <= 1'b1;
                  state <= ST_ACK;
               end else begin
                  state <= ST_CL_WAIT;
               end
            end
            ST_CL_WAIT: begin
               if (wait_cnt == CL_LAST) begin
                  wait_cnt  <= '0;
                  ack_q     <= 1'b1;
                  wbs_dat_o <= rd_pipe;
                  state     <= ST_ACK;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_ACK: begin
               wait_cnt <= '0;
               state    <= ST_PRECHARGE;
            end
            ST_PRECHARGE: begin
               if (wait_cnt == RP_LAST) begin
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_REFRESH: begin
               if (wait_cnt == RFC_LAST) begin
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               wait_cnt <= '0;
               state    <= ST_INIT;
            end
         endcase

         // Placed after the FSM so a due flag raised on the REFRESH entry edge is kept.
         if (state != ST_INIT) begin
            if (ref_cnt == REF_LAST) begin
               ref_cnt     <= '0;
               refresh_due <= 1'b1;
            end else begin
               ref_cnt <= ref_cnt + 1'b1;
            end
         end
      end
   end

   // Storage survives reset; reset only holds the FSM in INIT so nothing commits.
   always_ff @(posedge wb_clk_i) begin
      if (state == ST_RW) begin
         if (req_we) begin
            mem[req_idx] <= req_dat;
         end
         rd_pipe <= mem[req_idx];
      end
   end

endmodule

// File: tb/tb_sdram_uut.sv
// Randomized bench for sdram_uut: a word-indexed memory model and cycle-count
// expectations derived from the documented access timing.
module tb_sdram_uut;

   localparam int INIT_CYCLES = 8;
   localparam int T_RCD       = 2;
   localparam int CAS_LAT     = 2;
   localparam int T_RP        = 2;
   localparam int T_RFC       = 4;
   localparam int WR_LAT      = T_RCD + 2;
   localparam int RD_LAT      = T_RCD + 2 + CAS_LAT;
   // From one ack to the next with stb held: precharge, one IDLE cycle, then the access.
   localparam int WR_SPACE    = T_RP + 1 + WR_LAT;
   localparam int RD_SPACE    = T_RP + 1 + RD_LAT;
   // A refresh costs the IDLE cycle that chooses it plus T_RFC cycles.
   localparam int REF_EXTRA   = T_RFC + 1;
   localparam int TIMEOUT     = 400;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat_i = '0;
   logic [31:0] adr = '0;
   logic        ack;
   logic [31:0] dat_o;
   logic [2:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int consec_acks = 0;
   logic prev_ack = 1'b0;
   logic [31:0] model_mem [int];

   sdram_uut dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst_n),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat_i),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ack && prev_ack) consec_acks <= consec_acks + 1;
      prev_ack <= ack;
   end

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 2) % 4096);
   endfunction

   task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      we = w; adr = a; dat_i = d; sel = s; stb = 1'b1; cyc = 1'b1;
      if (w) model_mem[idx_of(a)] = d;
   endtask

   task automatic release_bus();
      stb = 1'b0; cyc = 1'b0;
   endtask

   // Counts falling edges until ack is seen; returns TIMEOUT if it never comes.
   task automatic wait_ack(output int n);
      n = 1;
      @(negedge clk);
      while (!ack && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int lat);
      drive_req(w, a, d, s);
      wait_ack(lat);
      rd = dat_o;
      release_bus();
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int lat;
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", ack); end
      n_vec++;
      if (dat_o !== 32'h0) begin n_err++; $display("FAIL reset_dat: got %h expected 0", dat_o); end
      rst_n = 1'b1;
      access(1'b1, 32'h0000_0020, $urandom(), 4'hF, rd, lat);
      n_vec++;
      if (lat !== INIT_CYCLES + WR_LAT) begin
         n_err++; $display("FAIL first_ack_latency: got %0d expected %0d", lat, INIT_CYCLES + WR_LAT);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd;
      int lat;
      repeat (3) @(negedge clk);
      access(1'b1, 32'h0000_000C, 32'h1215_3524, 4'hF, rd, lat);
      n_vec++;
      if (lat !== WR_LAT) begin n_err++; $display("FAIL wr_latency: got %0d expected %0d", lat, WR_LAT); end
      repeat (3) @(negedge clk);
      access(1'b0, 32'h0000_000C, 32'h0, 4'hF, rd, lat);
      n_vec++;
      if (lat !== RD_LAT) begin n_err++; $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT); end
      n_vec++;
      if (rd !== 32'h1215_3524) begin n_err++; $display("FAIL rd_data: got %h expected 12153524", rd); end
      repeat (3) @(negedge clk);
      n_vec++;
      if (dat_o !== 32'h1215_3524) begin n_err++; $display("FAIL dat_hold: got %h expected 12153524", dat_o); end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [31:0] exp_d;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b1, 32'h0000_000C + 32'(4 * i), $urandom(), 4'hF);
         wait_ack(lat);
         n_vec++;
         if (lat !== ((i == 0) ? WR_LAT : WR_SPACE)) begin
            n_err++; $display("FAIL b2b_wr_spacing[%0d]: got %0d expected %0d", i, lat,
                              (i == 0) ? WR_LAT : WR_SPACE);
         end
      end
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b0, 32'h0000_000C + 32'(4 * i), 32'h0, 4'hF);
         wait_ack(lat);
         exp_d = model_mem[idx_of(32'h0000_000C + 32'(4 * i))];
         n_vec++;
         if (lat !== RD_SPACE) begin
            n_err++; $display("FAIL b2b_rd_spacing[%0d]: got %0d expected %0d", i, lat, RD_SPACE);
         end
         n_vec++;
         if (dat_o !== exp_d) begin
            n_err++; $display("FAIL b2b_rd_data[%0d]: got %h expected %h", i, dat_o, exp_d);
         end
      end
      release_bus();
      repeat (12) @(negedge clk);
      n_vec++;
      if (consec_acks !== 0) begin n_err++; $display("FAIL ack_single_cycle: got %0d doubles expected 0", consec_acks); end
   endtask

   task automatic test_alias();
      logic [31:0] rd, va, vb;
      int lat;
      va = $urandom();
      vb = ~va;
      repeat (3) @(negedge clk);
      access(1'b1, 32'h0000_000C, va, 4'hF, rd, lat);
      repeat (3) @(negedge clk);
      access(1'b1, 32'h0000_400C, vb, 4'h0, rd, lat);
      n_vec++;
      if (lat !== WR_LAT) begin n_err++; $display("FAIL alias_wr_latency: got %0d expected %0d", lat, WR_LAT); end
      repeat (3) @(negedge clk);
      access(1'b0, 32'h0000_000C, 32'h0, 4'hF, rd, lat);
      n_vec++;
      if (rd !== model_mem[idx_of(32'h0000_000C)]) begin
         n_err++; $display("FAIL alias_rd: got %h expected %h", rd, model_mem[idx_of(32'h0000_000C)]);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, a, exp_d;
      logic w;
      int lat;
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(3, 6)) @(negedge clk);
         a = (32'($urandom_range(0, 31)) << 2) | ($urandom() & 32'hFFFF_C003);
         w = 1'($urandom_range(0, 1));
         if (!model_mem.exists(idx_of(a))) w = 1'b1;
         exp_d = w ? 32'h0 : model_mem[idx_of(a)];
         access(w, a, $urandom(), 4'($urandom_range(0, 15)), rd, lat);
         n_vec++;
         if (lat !== (w ? WR_LAT : RD_LAT)) begin
            n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, w ? WR_LAT : RD_LAT);
         end
         if (!w) begin
            n_vec++;
            if (rd !== exp_d) begin n_err++; $display("FAIL rand_rd[%0d]: got %h expected %h", i, rd, exp_d); end
         end
      end
   endtask

   task automatic test_refresh();
      logic [31:0] rd, a;
      int lat;
      int n_long = 0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 120; i++) begin
         drive_req(1'b1, 32'h0000_1000 + 32'(4 * i), $urandom(), 4'hF);
         wait_ack(lat);
         n_vec++;
         if (i == 0) begin
            if (lat !== WR_LAT && lat !== WR_LAT + REF_EXTRA) begin
               n_err++; $display("FAIL ref_first_latency: got %0d expected %0d or %0d", lat, WR_LAT,
                                 WR_LAT + REF_EXTRA);
            end
         end else begin
            if (lat == WR_SPACE + REF_EXTRA) n_long++;
            if (lat !== WR_SPACE && lat !== WR_SPACE + REF_EXTRA) begin
               n_err++; $display("FAIL ref_spacing[%0d]: got %0d expected %0d or %0d", i, lat, WR_SPACE,
                                 WR_SPACE + REF_EXTRA);
            end
         end
      end
      release_bus();
      n_vec++;
      if (n_long < 1) begin n_err++; $display("FAIL ref_seen: got %0d refresh gaps expected >=1", n_long); end
      for (int i = 0; i < 8; i++) begin
         repeat (3) @(negedge clk);
         a = 32'h0000_1000 + 32'(4 * $urandom_range(0, 119));
         access(1'b0, a, 32'h0, 4'hF, rd, lat);
         n_vec++;
         if (lat >= TIMEOUT || rd !== model_mem[idx_of(a)]) begin
            n_err++; $display("FAIL ref_rd[%0d]: got %h lat %0d expected %h", i, rd, lat, model_mem[idx_of(a)]);
         end
      end
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] rd, old_d;
      int lat;
      int acks = 0;
      repeat (3) @(negedge clk);
      drive_req(1'b0, 32'h0000_000C, 32'h0, 4'hF);
      repeat (4) begin @(negedge clk); if (ack) acks++; end
      rst_n = 1'b0;
      repeat (3) begin @(negedge clk); if (ack) acks++; end
      n_vec++;
      if (dat_o !== 32'h0) begin n_err++; $display("FAIL cl_reset_dat: got %h expected 0", dat_o); end
      release_bus();
      rst_n = 1'b1;
      repeat (20) begin @(negedge clk); if (ack) acks++; end
      n_vec++;
      if (acks !== 0) begin n_err++; $display("FAIL cl_reset_ack: got %0d acks expected 0", acks); end
      access(1'b0, 32'h0000_000C, 32'h0, 4'hF, rd, lat);
      n_vec++;
      if (rd !== model_mem[idx_of(32'h0000_000C)]) begin
         n_err++; $display("FAIL cl_reset_rd: got %h expected %h", rd, model_mem[idx_of(32'h0000_000C)]);
      end
      // A write aborted while still in ACTIVE must leave the old word in place.
      old_d = model_mem[idx_of(32'h0000_0010)];
      repeat (3) @(negedge clk);
      drive_req(1'b1, 32'h0000_0010, ~old_d, 4'hF);
      model_mem[idx_of(32'h0000_0010)] = old_d;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      release_bus();
      rst_n = 1'b1;
      access(1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, lat);
      n_vec++;
      if (rd !== old_d) begin n_err++; $display("FAIL aborted_write: got %h expected %h", rd, old_d); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_alias();
      test_random();
      test_refresh();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: simulation did not complete");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
